// File: rtl/shift_pipe.sv
// shift_pipe: log2(N)-stage barrel shifter/rotator with valid/ready flow.
// Stage k applies a shift of 2^k when amount bit k is set.
module shift_pipe #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_busy
);

  localparam int SHW = $clog2(N);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  logic           adv;

  logic [SHW-1:0] vld_q, vld_d;
  logic [N-1:0]   dat_q [SHW];
  logic [N-1:0]   dat_d [SHW];
  logic [2:0]     op_q  [SHW];
  logic [2:0]     op_d  [SHW];
  logic [SHW-1:0] amt_q [SHW];
  logic [SHW-1:0] amt_d [SHW];

  logic [SHW-1:0] src_vld;
  logic [N-1:0]   src_dat [SHW];
  logic [2:0]     src_op  [SHW];
  logic [SHW-1:0] src_amt [SHW];
  logic [N-1:0]   sft     [SHW];

  logic           unused_ok;

  function automatic logic [N-1:0] shf(
    input logic [N-1:0] d,
    input logic [2:0]   op,
    input int           sh
  );
    logic [N-1:0] r;
    r = d;
    case (op)
      OP_SLL: r = d << sh;
      OP_SRL: r = d >> sh;
      OP_SRA: r = N'($signed(d) >>> sh);
      OP_ROR: r = (d >> sh) | (d << (N - sh));
      OP_ROL: r = (d << sh) | (d >> (N - sh));
      default: r = d;
    endcase
    return r;
  endfunction

  assign o_valid  = vld_q[SHW-1];
  assign o_result = dat_q[SHW-1];
  assign o_busy   = |vld_q;
  assign adv      = i_ready | ~o_valid;
  assign o_ready  = adv;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Reserved ops enter as zero so every later stage keeps them zero.
      assign src_vld[k] = i_valid;
      assign src_dat[k] = (i_op > OP_ROL) ? '0 : i_a;
      assign src_op[k]  = i_op;
      assign src_amt[k] = i_b[SHW-1:0];
    end else begin : g_body
      assign src_vld[k] = vld_q[k-1];
      assign src_dat[k] = dat_q[k-1];
      assign src_op[k]  = op_q[k-1];
      assign src_amt[k] = amt_q[k-1];
    end
    assign sft[k] = src_amt[k][k]
                  ? shf(src_dat[k], src_op[k], 1 << k)
                  : src_dat[k];
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    op_d  = op_q;
    amt_d = amt_q;
    if (adv) begin
      for (int k = 0; k < SHW; k++) begin
        vld_d[k] = src_vld[k];
        dat_d[k] = sft[k];
        op_d[k]  = src_op[k];
        amt_d[k] = src_amt[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        dat_q[k] <= '0;
        op_q[k]  <= '0;
        amt_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      op_q  <= op_d;
      amt_q <= amt_d;
    end
  end

  assign unused_ok = ^{i_b[N-1:SHW], op_q[SHW-1], amt_q[SHW-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed + random checks of shift_pipe (N=32)
// against a transaction-level pipeline model.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic        ir;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        ov;
  logic        ordy;
  logic        busy;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          v;
    logic [31:0] r;
  } ent_t;

  ent_t        m [5];
  logic [31:0] cur_exp;
  bit          xfer;
  bit          last_stall;
  logic [31:0] last_res;
  bit          rnd_ready;
  int          stall_left;

  shift_pipe #(.N(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (iv),
    .o_ready  (ordy),
    .i_a      (a),
    .i_b      (b),
    .i_op     (op),
    .o_valid  (ov),
    .i_ready  (ir),
    .o_result (res),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refm(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [2:0]  o
  );
    int s;
    s = int'(y % 32);
    case (o)
      3'd0: return x << s;
      3'd1: return x >> s;
      3'd2: return $signed(x) >>> s;
      3'd3: return (x >> s) | (x << (32 - s));
      3'd4: return (x << s) | (x >> (32 - s));
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_busy();
    bit any;
    any = 0;
    foreach (m[i]) any |= m[i].v;
    return any;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit adv;
    if (rnd_ready) ir = ($urandom_range(0, 3) != 0);
    else if (stall_left > 0 && ov) begin
      ir = 1'b0;
      stall_left--;
    end else ir = 1'b1;
    @(negedge clk);
    if (rst_n) begin
      chk("valid", {63'b0, ov}, {63'b0, m[4].v});
      chk("busy", {63'b0, busy}, {63'b0, model_busy()});
      chk("ready", {63'b0, ordy}, {63'b0, ir | !m[4].v});
      if (m[4].v) chk("result", {32'b0, res}, {32'b0, m[4].r});
      if (last_stall) chk("hold", {32'b0, res}, {32'b0, last_res});
    end
    last_stall = ov && !ir && rst_n;
    last_res   = res;
    adv  = ir || !m[4].v;
    xfer = iv && adv && rst_n;
    if (!rst_n) begin
      foreach (m[i]) m[i] = '{0, 32'h0};
      last_stall = 0;
    end else if (adv) begin
      for (int k = 4; k > 0; k--) m[k] = m[k-1];
      m[0] = '{iv, cur_exp};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb,
                      input logic [2:0] xo, input logic [31:0] xe);
    bool_done: begin end
    iv = 1'b1;
    a = xa;
    b = xb;
    op = xo;
    cur_exp = xe;
    for (int t = 0; t < 40; t++) begin
      step();
      if (xfer) break;
    end
    if (!xfer) chk("send_timeout", 64'd0, 64'd1);
    iv = 1'b0;
  endtask

  task automatic drain();
    iv = 1'b0;
    for (int t = 0; t < 60 && model_busy(); t++) step();
    step();
    chk("drain_busy", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    rst_n = 1'b0;
    iv = 1'b0;
    ir = 1'b1;
    a = '0;
    b = '0;
    op = '0;
    cur_exp = '0;
    rnd_ready = 0;
    stall_left = 0;
    last_stall = 0;
    last_res = '0;
    foreach (m[i]) m[i] = '{0, 32'h0};
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_result", {32'b0, res}, 64'd0);

    send(32'h8000_0000, 32'd4, 3'd2, 32'hF800_0000);
    send(32'hFFFF_FFFF, 32'd37, 3'd1, 32'h07FF_FFFF);
    send(32'h0000_0001, 32'd31, 3'd0, 32'h8000_0000);
    send(32'h0000_0001, 32'd1, 3'd3, 32'h8000_0000);
    send(32'h8000_0000, 32'd1, 3'd4, 32'h0000_0001);
    for (int o = 0; o < 5; o++) begin
      ra = $urandom;
      send(ra, 32'd0, 3'(o), ra);
      send(ra, 32'h40, 3'(o), ra);
    end
    for (int o = 5; o < 8; o++) send($urandom, $urandom, 3'(o), 32'h0);
    drain();

    stall_left = 3;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = 32'(i * 5 + 1);
      ro = 3'(i % 5);
      send(ra, rb, ro, refm(ra, rb, ro));
    end
    drain();

    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) step();
      send(ra, rb, ro, refm(ra, rb, ro));
    end
    rnd_ready = 0;
    drain();

    for (int i = 0; i < 3; i++) send($urandom, 32'd3, 3'd0, 32'h0);
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", {63'b0, ov}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_ready", {63'b0, ordy}, 64'd1);
    chk("rst_res2", {32'b0, res}, 64'd0);
    for (int i = 0; i < 10; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
